// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store unit with an internal word RAM.
// A request is accepted in IDLE, legal accesses read the addressed word (RD),
// stores then write back the merged word (WR), and every accepted request
// ends with a one-cycle response (RESP). Illegal requests skip the RAM.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid, req_ready  request handshake (ready only when idle)
//   mem_read, mem_write   access type (load / store)
//   funct3                size/sign: LB,LH,LW,LBU,LHU / SB,SH,SW
//   addr, wdata           byte address, store data
//   resp_valid            one-cycle completion pulse
//   rdata, err            load result / illegal-request flag, held between responses
//   busy                  high whenever not idle
module load_store_unit #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]    state;
    logic [AW+1:0] cap_addr;
    logic [31:0]   cap_wdata;
    logic [2:0]    cap_funct3;
    logic          cap_read;
    logic [31:0]   rd_word;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          illegal;
    logic [31:0]   ram_q;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;
    logic [31:0]   store_merge;
    logic [4:0]    byte_lsb;
    logic [4:0]    half_lsb;
    logic          unused_addr_bits;

    // Upper address bits are ignored so addresses wrap around the RAM.
    assign unused_addr_bits = ^addr[31:AW+2];

    assign req_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);
    assign idx       = cap_addr[AW+1:2];
    assign ram_q     = mem[idx];
    assign byte_lsb  = {cap_addr[1:0], 3'b000};
    assign half_lsb  = {cap_addr[1], 4'b0000};

    // Legality is judged on the live request inputs at the accept edge.
    always_comb begin
        illegal = 1'b0;
        if (mem_read && mem_write) begin
            illegal = 1'b1;
        end else if (mem_read) begin
            case (funct3)
                3'd0, 3'd4: illegal = 1'b0;
                3'd1, 3'd5: illegal = addr[0];
                3'd2:       illegal = (addr[1:0] != 2'b00);
                default:    illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'd0:    illegal = 1'b0;
                3'd1:    illegal = addr[0];
                3'd2:    illegal = (addr[1:0] != 2'b00);
                default: illegal = 1'b1;
            endcase
        end
    end

    // Little-endian lane select: shift the addressed byte/half down to bit 0.
    always_comb begin
        shifted = ram_q >> byte_lsb;
        case (cap_funct3)
            3'd0:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    load_ext = {24'd0, shifted[7:0]};
            3'd5:    load_ext = {16'd0, shifted[15:0]};
            default: load_ext = ram_q;
        endcase
    end

    always_comb begin
        store_merge = rd_word;
        case (cap_funct3)
            3'd0:    store_merge[byte_lsb +: 8]  = cap_wdata[7:0];
            3'd1:    store_merge[half_lsb +: 16] = cap_wdata[15:0];
            default: store_merge = cap_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && (mem_read || mem_write)) begin
                        cap_addr   <= addr[AW+1:0];
                        cap_wdata  <= wdata;
                        cap_funct3 <= funct3;
                        // Only legal requests reach RD/WR, and those have
                        // exactly one of read/write set, so read alone decides.
                        cap_read   <= mem_read;
                        if (illegal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            err        <= 1'b1;
                            rdata      <= '0;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    rd_word <= ram_q;
                    if (cap_read) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        err        <= 1'b0;
                        rdata      <= load_ext;
                    end else begin
                        state <= WR;
                    end
                end
                WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    err        <= 1'b0;
                    rdata      <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM is not reset; a reset edge during WR suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && state == WR) begin
            mem[idx] <= store_merge;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.DEPTH_WORDS(256)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .resp_valid(resp_valid), .rdata(rdata),
        .err(err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Issue one request, then measure the cycle (1 = right after the accept
    // edge) in which resp_valid appears, and check the response contents.
    task automatic do_req(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int lat,
                          input logic e_err, input logic [31:0] e_rdata);
        int got;
        req_valid = 1'b1; mem_read = rd; mem_write = wr;
        funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        got = 0;
        for (int c = 1; c <= 6; c++) begin
            if (resp_valid) begin
                got = c;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_latency"}, got, lat);
        check({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
        check({tag, "_rdata"}, rdata, e_rdata);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_idle"}, {30'd0, busy, req_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        reset = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = '0; wdata = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0; #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Request with neither read nor write is ignored.
        req_valid = 1'b1;
        @(posedge clk); #1;
        check("noop_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("noop_resp", {31'd0, resp_valid}, 32'd0);
        req_valid = 1'b0;

        do_req("sw10", 0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 3, 0, 32'h0);
        do_req("lw10", 1, 0, 3'd2, 32'h10, 32'h0, 2, 0, 32'hDEADBEEF);
        do_req("sb11", 0, 1, 3'd0, 32'h11, 32'h80, 3, 0, 32'h0);
        do_req("lb11", 1, 0, 3'd0, 32'h11, 32'h0, 2, 0, 32'hFFFFFF80);
        do_req("lbu11", 1, 0, 3'd4, 32'h11, 32'h0, 2, 0, 32'h00000080);
        do_req("lw10b", 1, 0, 3'd2, 32'h10, 32'h0, 2, 0, 32'hDEAD80EF);

        do_req("sw20", 0, 1, 3'd2, 32'h20, 32'h11223344, 3, 0, 32'h0);
        do_req("sh22", 0, 1, 3'd1, 32'h22, 32'h00008001, 3, 0, 32'h0);
        do_req("lh22", 1, 0, 3'd1, 32'h22, 32'h0, 2, 0, 32'hFFFF8001);
        do_req("lhu22", 1, 0, 3'd5, 32'h22, 32'h0, 2, 0, 32'h00008001);
        do_req("lw20", 1, 0, 3'd2, 32'h20, 32'h0, 2, 0, 32'h80013344);

        // Illegal requests: immediate error response, no memory effect.
        do_req("sw14", 0, 1, 3'd2, 32'h14, 32'hCAFEF00D, 3, 0, 32'h0);
        do_req("lw13_ill", 1, 0, 3'd2, 32'h13, 32'h0, 1, 1, 32'h0);
        do_req("sh15_ill", 0, 1, 3'd1, 32'h15, 32'h0000FFFF, 1, 1, 32'h0);
        do_req("lw14_chk", 1, 0, 3'd2, 32'h14, 32'h0, 2, 0, 32'hCAFEF00D);
        do_req("ld_f3_ill", 1, 0, 3'd3, 32'h10, 32'h0, 1, 1, 32'h0);
        do_req("st_f3_ill", 0, 1, 3'd3, 32'h10, 32'h0, 1, 1, 32'h0);
        do_req("rw_ill", 1, 1, 3'd2, 32'h10, 32'h0, 1, 1, 32'h0);
        do_req("lw10_chk", 1, 0, 3'd2, 32'h10, 32'h0, 2, 0, 32'hDEAD80EF);

        // Wrap-around: 0x400 maps to word 0 with 256 words.
        do_req("sw400", 0, 1, 3'd2, 32'h400, 32'h12345678, 3, 0, 32'h0);
        do_req("lw0", 1, 0, 3'd2, 32'h0, 32'h0, 2, 0, 32'h12345678);

        // Reset during WR aborts the store.
        do_req("sw30", 0, 1, 3'd2, 32'h30, 32'h55555555, 3, 0, 32'h0);
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
        funct3 = 3'd2; addr = 32'h30; wdata = 32'hAAAAAAAA;
        @(posedge clk); #1;
        check("abort_rd_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("abort_wr_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_resp", {31'd0, resp_valid}, 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        check("abort_no_resp", seen, 0);
        do_req("lw30", 1, 0, 3'd2, 32'h30, 32'h0, 2, 0, 32'h55555555);

        // req_valid held high: inputs changed after accept are ignored and
        // the next request is taken only once the unit is back in IDLE.
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
        funct3 = 3'd2; addr = 32'h34; wdata = 32'h01020304;
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; addr = 32'h10; wdata = 32'h0;
        @(posedge clk); #1;
        check("hold_c2_resp", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("hold_st_resp", {31'd0, resp_valid}, 32'd1);
        check("hold_st_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        check("hold_idle_busy", {31'd0, busy}, 32'd0);
        check("hold_idle_resp", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("hold_reaccept_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("hold_ld_resp", {31'd0, resp_valid}, 32'd1);
        check("hold_ld_rdata", rdata, 32'hDEAD80EF);
        @(posedge clk); #1;
        do_req("lw34", 1, 0, 3'd2, 32'h34, 32'h0, 2, 0, 32'h01020304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
